majority_voter: RTL and testbench

Triple-modular-redundancy bit voter with per-voter fault tracking. Combinationally outputs the 2-of-3 majority of three 1-bit votes, and also provides a registered copy, unanimity/popcount status, and sticky per-voter fault flags for voters that persistently disagree with the majority. It sits between redundant replicas of a control bit and the logic that consumes the voted value.

---
 rtl/majority_voter.sv | 113 +++++++++++
 tb/tb_majority_voter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/majority_voter.sv
// majority_voter
//   Triple-modular-redundancy bit voter with per-voter fault tracking.
//   Produces the 2-of-3 majority of three vote bits combinationally, plus a
//   registered copy, unanimity/popcount status and sticky per-voter fault
//   flags for voters that disagree with the majority for FAULT_LIMIT
//   consecutive cycles.
//
// Parameters
//   FAULT_LIMIT     consecutive disagreeing cycles that mark a voter faulty (1..255)
//
// Ports
//   votes           in   [2:0]  one vote bit per voter, bit i is voter i
//   y               out         combinational majority of votes
//   clk             in          rising-edge clock
//   reset           in          asynchronous active-high reset
//   clear_fault     in          synchronous clear of fault flags and run counters
//   y_q             out         y registered on clk
//   unanimous       out         1 when votes is 3'b000 or 3'b111
//   count           out  [1:0]  number of 1 bits in votes
//   fault           out  [2:0]  sticky fault flag per voter
//   disagree_total  out  [15:0] saturating count of non-unanimous cycles
//
// Build option
//   MAJORITY_VOTER_STATS_EN  when defined, disagree_total is a real counter;
//                            otherwise it is tied to zero and no register is built.
module majority_voter #(
   parameter int unsigned FAULT_LIMIT = 4
) (
   input  logic [2:0]  votes,
   output logic        y,
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_fault,
   output logic        y_q,
   output logic        unanimous,
   output logic [1:0]  count,
   output logic [2:0]  fault,
   output logic [15:0] disagree_total
);

   localparam int unsigned RUN_W = $clog2(FAULT_LIMIT + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FAULT_LIMIT);

   logic [2:0][RUN_W-1:0] run_q, run_d;
   logic [2:0]            fault_q, fault_d;

   // Combinational status
   always_comb begin
      y         = (votes[0] & votes[1]) | (votes[0] & votes[2]) | (votes[1] & votes[2]);
      unanimous = (votes == 3'b000) || (votes == 3'b111);
      count     = 2'(votes[0]) + 2'(votes[1]) + 2'(votes[2]);
   end

   // Per-voter consecutive-disagreement tracking; clear wins over a same-edge set.
   always_comb begin
      run_d   = run_q;
      fault_d = fault_q;
      for (int unsigned i = 0; i < 3; i++) begin
         if (clear_fault) begin
            run_d[i]   = '0;
            fault_d[i] = 1'b0;
         end else if (votes[i] != y) begin
            if (run_q[i] != RUN_MAX) begin
               run_d[i] = run_q[i] + 1'b1;
            end
            if (run_d[i] == RUN_MAX) begin
               fault_d[i] = 1'b1;
            end
         end else begin
            run_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         y_q     <= 1'b0;
         run_q   <= '0;
         fault_q <= '0;
      end else begin
         y_q     <= y;
         run_q   <= run_d;
         fault_q <= fault_d;
      end
   end

   assign fault = fault_q;

`ifdef MAJORITY_VOTER_STATS_EN
   logic [15:0] total_q, total_d;

   // Saturating count of cycles where the voters were not unanimous; only reset clears it.
   always_comb begin
      total_d = total_q;
      if (!unanimous && (total_q != 16'hFFFF)) begin
         total_d = total_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         total_q <= '0;
      end else begin
         total_q <= total_d;
      end
   end

   assign disagree_total = total_q;
`else
   assign disagree_total = '0;
`endif

endmodule

// File: tb/tb_majority_voter.sv
// tb_majority_voter
//   Self-checking bench for majority_voter (FAULT_LIMIT = 4). Directed
//   scenarios followed by randomized votes, all compared against a
//   behavioural model built from popcounts and integer run counters.
//   Expected disagree_total follows MAJORITY_VOTER_STATS_EN.
module tb_majority_voter;

   localparam int LIMIT = 4;
`ifdef MAJORITY_VOTER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic [2:0]  votes;
   logic        y;
   logic        clk;
   logic        reset;
   logic        clear_fault;
   logic        y_q;
   logic        unanimous;
   logic [1:0]  count;
   logic [2:0]  fault;
   logic [15:0] disagree_total;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   int m_run [3];
   bit m_fault [3];
   int m_total;
   bit m_yq;

   majority_voter #(.FAULT_LIMIT(LIMIT)) dut (
      .votes          (votes),
      .y              (y),
      .clk            (clk),
      .reset          (reset),
      .clear_fault    (clear_fault),
      .y_q            (y_q),
      .unanimous      (unanimous),
      .count          (count),
      .fault          (fault),
      .disagree_total (disagree_total)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] m_fault_vec();
      return {m_fault[2], m_fault[1], m_fault[0]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_run[i]   = 0;
         m_fault[i] = 1'b0;
      end
      m_total = 0;
      m_yq    = 1'b0;
   endtask

   task automatic model_edge(input logic [2:0] v, input logic clr);
      int pc;
      bit maj;
      pc  = $countones(v);
      maj = (pc >= 2);
      for (int i = 0; i < 3; i++) begin
         if (clr) begin
            m_run[i]   = 0;
            m_fault[i] = 1'b0;
         end else if (v[i] != maj) begin
            m_run[i] = (m_run[i] < LIMIT) ? m_run[i] + 1 : LIMIT;
            if (m_run[i] == LIMIT) m_fault[i] = 1'b1;
         end else begin
            m_run[i] = 0;
         end
      end
      if (STATS && pc != 0 && pc != 3 && m_total < 65535) m_total++;
      m_yq = maj;
   endtask

   task automatic check_comb(input string tag);
      int pc;
      pc = $countones(votes);
      check({tag, ".y"}, 32'(y), 32'(pc >= 2));
      check({tag, ".count"}, 32'(count), 32'(pc));
      check({tag, ".unan"}, 32'(unanimous), 32'(pc == 0 || pc == 3));
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".y_q"}, 32'(y_q), 32'(m_yq));
      check({tag, ".fault"}, 32'(fault), 32'(m_fault_vec()));
      check({tag, ".total"}, 32'(disagree_total), 32'(m_total));
   endtask

   // Apply one cycle of stimulus, check combinational outputs before the edge
   // and registered outputs just after it.
   task automatic step(input logic [2:0] v, input logic clr, input string tag);
      votes       = v;
      clear_fault = clr;
      #1;
      check_comb(tag);
      @(posedge clk);
      model_edge(v, clr);
      #1;
      check_regs(tag);
   endtask

   // Assert reset between edges; outputs must clear without a clock edge.
   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b1;
      #1;
      model_reset();
      check_regs({tag, ".async"});
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [2:0] sweep_y, sweep_u;
      logic [7:0] sweep_c [8];
      sweep_y = '0;
      sweep_u = '0;
      reset       = 1'b1;
      clear_fault = 1'b0;
      votes       = 3'b000;
      model_reset();

      // Combinational sweep against the literal truth table
      begin
         logic [7:0] exp_y;
         logic [15:0] exp_c;
         exp_y = 8'b1110_1000;
         exp_c = {2'd3, 2'd2, 2'd2, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0};
         for (int i = 0; i < 8; i++) begin
            votes = 3'(i);
            #10;
            check("sweep.y", 32'(y), 32'(exp_y[i]));
            check("sweep.count", 32'(count), 32'(exp_c[2*i +: 2]));
            check("sweep.unan", 32'(unanimous), 32'(i == 0 || i == 7));
         end
      end

      // Reset held: registers stay at reset values across edges
      votes = 3'b110;
      @(posedge clk);
      #1;
      check("rst_hold.y_q", 32'(y_q), 32'd0);
      check_regs("rst_hold");
      @(negedge clk);
      reset = 1'b0;

      step(3'b110, 1'b0, "yq_lat");
      check("yq_lat.const", 32'(y_q), 32'd1);

      // Voter 2 disagrees persistently
      do_reset("r1");
      for (int i = 1; i <= 4; i++) begin
         step(3'b011, 1'b0, "v2run");
         if (i == 3) check("v2run.edge3", 32'(fault), 32'd0);
         if (i == 4) check("v2run.edge4", 32'(fault), 32'b100);
      end
      for (int i = 0; i < 3; i++) step(3'b111, 1'b0, "v2sticky");
      check("v2sticky.const", 32'(fault), 32'b100);

      // Alternating disagreement never builds a run
      step(3'b111, 1'b1, "clr");
      for (int i = 0; i < 10; i++) step((i % 2 == 0) ? 3'b101 : 3'b111, 1'b0, "alt");
      check("alt.const", 32'(fault), 32'd0);

      // Clear beats a same-edge set
      for (int i = 0; i < 4; i++) step(3'b110, 1'b0, "v0set");
      check("v0set.const", 32'(fault), 32'b001);
      for (int i = 0; i < 3; i++) step(3'b101, 1'b0, "v1pre");
      step(3'b101, 1'b1, "clr_win");
      check("clr_win.const", 32'(fault), 32'd0);

      // Statistics counter
      do_reset("r2");
      for (int i = 0; i < 5; i++) step(3'b001, 1'b0, "st_dis");
      for (int i = 0; i < 3; i++) step(3'b000, 1'b0, "st_agr");
      check("stats.const", 32'(disagree_total), STATS ? 32'd5 : 32'd0);
      do_reset("r3");
      check("stats.rst", 32'(disagree_total), 32'd0);

      // Randomized: mostly one flipped voter at a time, with occasional clears
      begin
         int bad;
         logic [2:0] v;
         bad = 0;
         for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) bad = $urandom_range(0, 2);
            v = ($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000;
            if ($urandom_range(0, 3) != 0) v[bad] = ~v[bad];
            if ($urandom_range(0, 9) == 0) v = 3'($urandom);
            step(v, ($urandom_range(0, 31) == 0), "rand");
            if ($urandom_range(0, 127) == 0) do_reset("rrand");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
